// File: rtl/rtc_alarm.sv
// rtc_alarm: bus-mapped BCD hh:mm:ss real-time clock with a parametrised
// one-second prescaler, run/stop control, alarm compare with a sticky
// pending flag, an interrupt output and a per-second tick pulse.
//
// Bus handshake: sel_in acts as the request valid. ready_out mirrors sel_in,
// so every selected cycle completes at once with zero wait states. A write
// takes effect on the clock edge that closes a selected cycle with a non-zero
// write_mask_in. read_value_out is combinational and valid in the same cycle.
module rtc_alarm #(
    parameter int PRESCALE     = 12000000,
    parameter bit RUN_AT_RESET = 1'b1
) (
    input  logic        clk_in,
    input  logic        reset,
    output logic        tick_out,
    output logic        irq_out,
    input  logic [31:0] address_in,
    input  logic        sel_in,
    output logic [31:0] read_value_out,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] write_value_in,
    output logic        ready_out
);

    localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] count;
    logic [23:0]   time_q;
    logic [23:0]   alarm_q;
    logic [23:0]   time_next;
    logic          alarm_en;
    logic          run;
    logic          irq_en;
    logic          pending;

    logic          tick;
    logic          wr;
    logic          time_wr;
    logic          alarm_wr;
    logic          ctrl_wr;
    logic          alarm_hit;
    logic          pend_clr;
    logic [31:0]   rdata;

    // Address bits outside [3:2] and data bits above the widest register are
    // not decoded; the block select is produced outside this module.
    logic          unused_bits;
    assign unused_bits = &{1'b0, address_in[31:4], address_in[1:0],
                           write_value_in[31:25]};

    // Merge byte lanes 0..2 of the write data into a 24-bit time-layout value.
    function automatic logic [23:0] merge24(input logic [23:0] old,
                                            input logic [31:0] data,
                                            input logic [3:0]  mask);
        logic [23:0] res;
        res = old;
        if (mask[0]) res[7:0]   = data[7:0];
        if (mask[1]) res[15:8]  = data[15:8];
        if (mask[2]) res[23:16] = data[23:16];
        return res;
    endfunction

    assign tick      = run && (count == LAST);
    assign wr        = sel_in && (write_mask_in != 4'b0000);
    assign time_wr   = wr && (address_in[3:2] == 2'd0);
    assign alarm_wr  = wr && (address_in[3:2] == 2'd1);
    assign ctrl_wr   = wr && (address_in[3:2] == 2'd2);
    assign pend_clr  = ctrl_wr && write_mask_in[0] && write_value_in[2];
    // A tick discarded by a simultaneous TIME write never evaluates the alarm.
    assign alarm_hit = tick && !time_wr && alarm_en && (time_next == alarm_q);

    assign tick_out  = tick;
    assign irq_out   = pending && irq_en;
    assign ready_out = sel_in;

    // Time-of-day increment; a digit at or above its limit rolls to zero and
    // carries, so out-of-range software values recover at their next carry.
    always_comb begin
        time_next = time_q;
        if (time_q[3:0] < 4'd9) begin
            time_next[3:0] = time_q[3:0] + 4'd1;
        end else begin
            time_next[3:0] = 4'd0;
            if (time_q[7:4] < 4'd5) begin
                time_next[7:4] = time_q[7:4] + 4'd1;
            end else begin
                time_next[7:4] = 4'd0;
                if (time_q[11:8] < 4'd9) begin
                    time_next[11:8] = time_q[11:8] + 4'd1;
                end else begin
                    time_next[11:8] = 4'd0;
                    if (time_q[15:12] < 4'd5) begin
                        time_next[15:12] = time_q[15:12] + 4'd1;
                    end else begin
                        time_next[15:12] = 4'd0;
                        if (time_q[23:20] >= 4'd2 && time_q[19:16] >= 4'd3) begin
                            time_next[23:16] = 8'h00;
                        end else if (time_q[19:16] < 4'd9) begin
                            time_next[19:16] = time_q[19:16] + 4'd1;
                        end else begin
                            time_next[19:16] = 4'd0;
                            time_next[23:20] = time_q[23:20] + 4'd1;
                        end
                    end
                end
            end
        end
    end

    // Prescaler: counts while running, wraps on the tick, restarts on a TIME write.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            count <= '0;
        end else if (time_wr || tick) begin
            count <= '0;
        end else if (run) begin
            count <= count + 1'b1;
        end
    end

    // Time-of-day register: a software write overrides a same-cycle tick.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            time_q <= 24'h000000;
        end else if (time_wr) begin
            time_q <= merge24(time_q, write_value_in, write_mask_in);
        end else if (tick) begin
            time_q <= time_next;
        end
    end

    // Alarm compare value and its enable bit in lane 3.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            alarm_q  <= 24'h000000;
            alarm_en <= 1'b0;
        end else if (alarm_wr) begin
            alarm_q <= merge24(alarm_q, write_value_in, write_mask_in);
            if (write_mask_in[3]) alarm_en <= write_value_in[24];
        end
    end

    // Control bits; run=0 written in a tick cycle still lets that tick complete.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            run    <= RUN_AT_RESET;
            irq_en <= 1'b0;
        end else if (ctrl_wr && write_mask_in[0]) begin
            run    <= write_value_in[0];
            irq_en <= write_value_in[1];
        end
    end

    // Sticky alarm flag: a new match outranks a simultaneous write-1-to-clear.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            pending <= 1'b0;
        end else if (alarm_hit) begin
            pending <= 1'b1;
        end else if (pend_clr) begin
            pending <= 1'b0;
        end
    end

    // Combinational register read mux; unused bits and address 3 read zero.
    always_comb begin
        rdata = 32'h0;
        case (address_in[3:2])
            2'd0:    rdata = {8'h00, time_q};
            2'd1:    rdata = {7'h00, alarm_en, alarm_q};
            2'd2:    rdata = {29'h0, pending, irq_en, run};
            default: rdata = 32'h0;
        endcase
        read_value_out = sel_in ? rdata : 32'h0;
    end

endmodule

// File: tb/tb_rtc_alarm.sv
// Bench for rtc_alarm with PRESCALE=4. A behavioural model keeps time as
// seconds-of-day arithmetic and is checked against the DUT on every cycle;
// directed literal reads pin the model, then a random bus phase runs.
module tb_rtc_alarm;
  localparam int P = 4;

  logic        clk_in;
  logic        reset;
  logic        tick_out;
  logic        irq_out;
  logic [31:0] address_in;
  logic        sel_in;
  logic [31:0] read_value_out;
  logic [3:0]  write_mask_in;
  logic [31:0] write_value_in;
  logic        ready_out;

  int checks = 0;
  int errors = 0;
  logic started = 1'b0;
  logic [31:0] exp_q[$];

  rtc_alarm #(.PRESCALE(P), .RUN_AT_RESET(1'b1)) dut (
    .clk_in(clk_in),
    .reset(reset),
    .tick_out(tick_out),
    .irq_out(irq_out),
    .address_in(address_in),
    .sel_in(sel_in),
    .read_value_out(read_value_out),
    .write_mask_in(write_mask_in),
    .write_value_in(write_value_in),
    .ready_out(ready_out)
  );

  // ---------------- clock / reset ----------------
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // ---------------- reference model ----------------
  logic [23:0] m_time;
  logic [23:0] m_alarm;
  logic        m_aen;
  logic        m_run;
  logic        m_ien;
  logic        m_pend;
  int          m_cnt;

  function automatic logic [7:0] bcd8(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Next second of the day, computed as seconds-of-day + 1 modulo 86400.
  function automatic logic [23:0] bump(input logic [23:0] t);
    int s, h, m, x;
    s = (int'(t[23:20]) * 10 + int'(t[19:16])) * 3600
      + (int'(t[15:12]) * 10 + int'(t[11:8])) * 60
      + int'(t[7:4]) * 10 + int'(t[3:0]);
    s = (s + 1) % 86400;
    h = s / 3600;
    m = (s / 60) % 60;
    x = s % 60;
    return {bcd8(h), bcd8(m), bcd8(x)};
  endfunction

  function automatic logic [23:0] lanes(input logic [23:0] old, input logic [31:0] d,
                                        input logic [3:0] mask);
    logic [23:0] r;
    r = old;
    for (int b = 0; b < 3; b++) if (mask[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic m_tick();
    return m_run && (m_cnt == P - 1);
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {8'h00, m_time};
      2'd1:    return {7'h00, m_aen, m_alarm};
      2'd2:    return {29'h0, m_pend, m_ien, m_run};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk_in) begin : model
    logic t, w, tw, setp, clrp;
    logic [1:0] a;
    logic [23:0] nx;
    if (reset) begin
      m_time = '0; m_alarm = '0; m_aen = 0; m_run = 1; m_ien = 0; m_pend = 0;
      m_cnt = 0;
      started = 1'b1;
    end else begin
      t    = m_tick();
      a    = address_in[3:2];
      w    = sel_in && (write_mask_in != 4'b0);
      tw   = w && (a == 2'd0);
      nx   = bump(m_time);
      setp = t && !tw && m_aen && (nx == m_alarm);
      clrp = w && (a == 2'd2) && write_mask_in[0] && write_value_in[2];
      if (tw || t) m_cnt = 0;
      else if (m_run) m_cnt = m_cnt + 1;
      if (tw) m_time = lanes(m_time, write_value_in, write_mask_in);
      else if (t) m_time = nx;
      if (w && a == 2'd1) begin
        m_alarm = lanes(m_alarm, write_value_in, write_mask_in);
        if (write_mask_in[3]) m_aen = write_value_in[24];
      end
      if (w && a == 2'd2 && write_mask_in[0]) begin
        m_run = write_value_in[0];
        m_ien = write_value_in[1];
      end
      if (setp) m_pend = 1'b1;
      else if (clrp) m_pend = 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare, away from the active edge.
  always @(negedge clk_in) begin
    if (started) begin
      check("tick_out", {31'h0, tick_out}, {31'h0, m_tick()});
      check("irq_out", {31'h0, irq_out}, {31'h0, m_pend && m_ien});
      check("ready_out", {31'h0, ready_out}, {31'h0, sel_in});
      check("read_value", read_value_out, sel_in ? m_read(address_in[3:2]) : 32'h0);
    end
  end

  // ---------------- driver tasks (entered and left at posedge+1) ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [3:0] mask, input logic [31:0] d);
    sel_in = 1'b1;
    address_in = {28'h0, a, 2'b00};
    write_mask_in = mask;
    write_value_in = d;
    idle(1);
    sel_in = 1'b0;
    write_mask_in = 4'h0;
  endtask

  task automatic expect_read(input logic [1:0] a, input logic [31:0] exp, input string name);
    exp_q.push_back(exp);
    sel_in = 1'b1;
    address_in = {28'h0, a, 2'b00};
    write_mask_in = 4'h0;
    @(negedge clk_in);
    check(name, read_value_out, exp_q.pop_front());
    @(posedge clk_in);
    #1;
    sel_in = 1'b0;
  endtask

  // Counts idle cycles until tick_out is high, bounded.
  task automatic wait_tick(output int n);
    n = 0;
    while (!tick_out && n < 3 * P + 30) begin
      idle(1);
      n++;
    end
    check("tick_wait", {31'h0, tick_out}, 32'h1);
  endtask

  task automatic pass_tick();
    int n;
    wait_tick(n);
    idle(1);
  endtask

  // ---------------- stimulus ----------------
  int tick_at[$];
  int exp_ticks[3] = '{3, 7, 11};
  int n;
  int r;
  logic [1:0] ra;

  initial begin
    reset = 1'b1;
    sel_in = 1'b0;
    address_in = '0;
    write_mask_in = '0;
    write_value_in = '0;
    idle(3);
    reset = 1'b0;

    // Reset state and tick cadence.
    check("tick_reset", {31'h0, tick_out}, 32'h0);
    check("irq_reset", {31'h0, irq_out}, 32'h0);
    sel_in = 1'b1;
    address_in = 32'h0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk_in);
      #1;
      if (k == 1) check("time_reset", read_value_out, 32'h0);
      if (tick_out) tick_at.push_back(k);
    end
    check("tick_count", tick_at.size(), 3);
    for (int i = 0; i < tick_at.size() && i < 3; i++)
      check("tick_cycle", tick_at[i], exp_ticks[i]);
    check("time_3_ticks", read_value_out, 32'h000003);
    sel_in = 1'b0;
    expect_read(2'd2, 32'h1, "ctrl_reset");

    // Rollovers.
    bus_write(2'd0, 4'hf, 32'h235958);
    pass_tick();
    expect_read(2'd0, 32'h235959, "roll_235959");
    pass_tick();
    expect_read(2'd0, 32'h000000, "roll_midnight");
    bus_write(2'd0, 4'hf, 32'h095959);
    pass_tick();
    expect_read(2'd0, 32'h100000, "roll_hour_digit");
    bus_write(2'd0, 4'hf, 32'h005959);
    pass_tick();
    expect_read(2'd0, 32'h010000, "roll_hour");

    // Alarm set, interrupt, clear.
    bus_write(2'd1, 4'hf, 32'h01000005);
    bus_write(2'd2, 4'hf, 32'h3);
    bus_write(2'd0, 4'hf, 32'h000003);
    pass_tick();
    expect_read(2'd2, 32'h3, "alarm_not_yet");
    pass_tick();
    expect_read(2'd2, 32'h7, "alarm_pending");
    check("irq_high", {31'h0, irq_out}, 32'h1);
    bus_write(2'd2, 4'hf, 32'h7);
    expect_read(2'd2, 32'h3, "alarm_cleared");
    check("irq_low", {31'h0, irq_out}, 32'h0);
    pass_tick();
    expect_read(2'd2, 32'h3, "alarm_no_reset");

    // Software write equal to ALARM does not set pending.
    bus_write(2'd0, 4'hf, 32'h000005);
    expect_read(2'd2, 32'h3, "sw_write_no_alarm");

    // TIME write in the tick cycle wins; next tick a full period later.
    wait_tick(n);
    bus_write(2'd0, 4'hf, 32'h101010);
    wait_tick(n);
    check("tick_after_write", n, 3);
    expect_read(2'd0, 32'h101010, "write_in_tick");

    // Stop and resume from the held counter value.
    bus_write(2'd0, 4'hf, 32'h120000);
    idle(1);
    bus_write(2'd2, 4'hf, 32'h0);
    idle(20);
    expect_read(2'd0, 32'h120000, "stopped_frozen");
    bus_write(2'd2, 4'hf, 32'h1);
    wait_tick(n);
    check("resume_count", n, 1);

    // Byte-lane write, deselected read, address 3.
    bus_write(2'd0, 4'hf, 32'h123456);
    bus_write(2'd0, 4'b0001, 32'h00FFFF27);
    expect_read(2'd0, 32'h123427, "lane_write");
    sel_in = 1'b0;
    address_in = 32'h0;
    @(negedge clk_in);
    check("desel_read", read_value_out, 32'h0);
    check("desel_ready", {31'h0, ready_out}, 32'h0);
    idle(1);
    bus_write(2'd3, 4'hf, 32'hFFFFFFFF);
    expect_read(2'd3, 32'h0, "addr3_read");

    // Random bus traffic against the model.
    bus_write(2'd2, 4'hf, 32'h3);
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 99);
      if (r < 25) begin
        ra = (r < 3) ? 2'd0 : 2'($urandom_range(1, 3));
        sel_in = 1'b1;
        address_in = {$urandom, ra, 2'($urandom_range(0, 3))};
        write_mask_in = 4'($urandom_range(1, 15));
        if (ra == 2'd2)
          write_value_in = {$urandom, 1'b0} | 32'($urandom_range(0, 9) != 0);
        else
          write_value_in = {7'($urandom), 1'($urandom), 8'h00,
                            bcd8($urandom_range(0, 1)), bcd8($urandom_range(0, 59))};
      end else if (r < 40) begin
        sel_in = 1'b1;
        address_in = $urandom;
        write_mask_in = 4'h0;
        write_value_in = $urandom;
      end else begin
        sel_in = 1'b0;
        address_in = $urandom;
        write_mask_in = 4'($urandom);
        write_value_in = $urandom;
      end
      idle(1);
    end
    sel_in = 1'b0;
    write_mask_in = 4'h0;

    // Reset mid-count.
    idle($urandom_range(1, 3));
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    expect_read(2'd0, 32'h0, "time_after_reset");
    expect_read(2'd2, 32'h1, "ctrl_after_reset");
    expect_read(2'd1, 32'h0, "alarm_after_reset");

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
